// File: rtl/reg_ctrl_bank.sv
// Register bank written one EXT_W lane at a time from a debounced WR strobe,
// with a control register for auto-increment, clear-all and LED page select.
module reg_ctrl_bank #(
    parameter  int DATA_W = 32,
    parameter  int N_REGS = 4,
    parameter  int EXT_W  = 8,
    parameter  int SPI_W  = 4,
    parameter  int LED_W  = 16,
    localparam int ADDR_W = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              WR,
    input  logic              sel_mux,
    input  logic              sel_dmux,
    input  logic [ADDR_W-1:0] i_extC,
    input  logic [EXT_W-1:0]  i_extD,
    input  logic [SPI_W-1:0]  SPI,
    output logic [DATA_W-1:0] out,
    output logic [LED_W-1:0]  led,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LANES     = DATA_W / EXT_W;
    localparam int LANE_W    = $clog2(LANES);
    localparam int PAGES     = DATA_W / LED_W;
    localparam int VIS_PAGES = (PAGES < 4) ? PAGES : 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_COMMIT
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_wr_meta;
    logic                r_wr_sync;
    logic                r_wr_prev;
    logic                w_req;
    logic [EXT_W-1:0]    w_src;
    // Only the functional ctrl field is kept; the spare bits have no readback path.
    logic [3:0]          r_ctrl;
    logic [DATA_W-1:0]   r_stage;
    logic [LANE_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_target;
    logic [ADDR_W-1:0]   r_wptr;
    logic [DATA_W-1:0]   r_regs [N_REGS];
    logic [DATA_W-1:0]   r_out;
    logic [DATA_W-1:0]   w_rd_next;
    logic                r_err;
    logic                w_ctrl_we;
    logic                w_lane_we;
    logic                w_commit;
    logic                w_drop;
    logic                w_clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_meta <= 1'b0;
            r_wr_sync <= 1'b0;
            r_wr_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each flop sample the old value of
            // its predecessor, which is what turns these three lines into a shift chain.
            r_wr_meta <= WR;
            r_wr_sync <= r_wr_meta;
            r_wr_prev <= r_wr_sync;
        end
    end

    assign w_req   = r_wr_sync & ~r_wr_prev;
    assign w_src   = sel_mux ? EXT_W'(SPI) : i_extD;
    assign w_clear = w_ctrl_we & w_src[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path through
        // the case statement can leave one unassigned and infer a latch.
        w_state_next = r_state;
        w_ctrl_we    = 1'b0;
        w_lane_we    = 1'b0;
        w_commit     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req && !sel_dmux) begin
                    w_ctrl_we = 1'b1;
                end else if (w_req) begin
                    w_lane_we    = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_req && !sel_dmux) begin
                    w_ctrl_we    = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_req) begin
                    w_lane_we = 1'b1;
                    if (r_ptr == LANE_W'(LANES - 1)) w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit     = 1'b1;
                w_drop       = w_req;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ctrl   <= '0;
            r_stage  <= '0;
            r_ptr    <= '0;
            r_target <= '0;
            r_wptr   <= '0;
            r_err    <= 1'b0;
            // NOTE: the data array is cleared by reset because its contents are
            // architecturally visible on out right after reset is released.
            for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
        end else begin
            if (w_ctrl_we) begin
                r_ctrl  <= w_src[3:0] & 4'b1101;
                r_stage <= '0;
                r_ptr   <= '0;
            end
            if (w_clear) begin
                for (int i = 0; i < N_REGS; i++) r_regs[i] <= '0;
            end
            if (w_lane_we) begin
                for (int l = 0; l < LANES; l++) begin
                    if (r_ptr == LANE_W'(l)) r_stage[l*EXT_W +: EXT_W] <= w_src;
                end
                r_ptr <= r_ptr + LANE_W'(1);
                if (r_state == ST_IDLE) r_target <= r_ctrl[0] ? r_wptr : i_extC;
            end
            if (w_commit) begin
                for (int i = 0; i < N_REGS; i++) begin
                    if (r_target == ADDR_W'(i)) r_regs[i] <= r_stage;
                end
                r_stage <= '0;
                r_ptr   <= '0;
                if (r_ctrl[0]) begin
                    r_wptr <= (r_wptr == ADDR_W'(N_REGS - 1)) ? '0 : r_wptr + ADDR_W'(1);
                end
            end
            if (w_drop) r_err <= 1'b1;
        end
    end

    // Read port forwards this cycle's register update so out tracks the array with no extra lag.
    always_comb begin
        w_rd_next = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (i_extC == ADDR_W'(i)) begin
                if (w_clear)                                  w_rd_next = '0;
                else if (w_commit && r_target == ADDR_W'(i)) w_rd_next = r_stage;
                else                                          w_rd_next = r_regs[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_out <= '0;
        else     r_out <= w_rd_next;
    end

    always_comb begin
        led = '0;
        for (int p = 0; p < VIS_PAGES; p++) begin
            if (r_ctrl[3:2] == 2'(p)) led = r_out[p*LED_W +: LED_W];
        end
    end

    assign out  = r_out;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_COMMIT);
    assign err  = r_err;

endmodule
